// File: rtl/axis_weight_memory_writer_pkg.sv
// Shared state type and default widths for the AXI-Stream weight memory writer.
// Also holds a helper that sizes the beat counter.
package axis_weight_memory_writer_pkg;

    localparam int DEFAULT_AXIS_BUS_BIT_WIDTH = 64;
    localparam int DEFAULT_PACK_FACTOR        = 2;
    localparam int DEFAULT_MEM_ADDR_WIDTH     = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } writer_state_e;

    // A single-beat row still needs a one-bit counter so the port widths stay legal.
    function automatic int beat_cnt_width(input int pack_factor);
        return (pack_factor > 1) ? $clog2(pack_factor) : 1;
    endfunction

endpackage

// File: rtl/axis_weight_memory_writer_row_packer.sv
// Packs accepted stream beats into one memory row, beat 0 in the LSBs.
// The row completes on the last slice or on s_last; missing slices read as zero.
module weight_row_packer
    import axis_weight_memory_writer_pkg::*;
#(
    parameter int AXIS_BUS_BIT_WIDTH = DEFAULT_AXIS_BUS_BIT_WIDTH,
    parameter int PACK_FACTOR        = DEFAULT_PACK_FACTOR
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      clear_i,
    input  logic                                      beat_valid_i,
    input  logic [AXIS_BUS_BIT_WIDTH-1:0]             beat_data_i,
    input  logic                                      beat_last_i,
    output logic                                      row_done_o,
    output logic [AXIS_BUS_BIT_WIDTH*PACK_FACTOR-1:0] row_data_o
);

    localparam int ROW_W = AXIS_BUS_BIT_WIDTH * PACK_FACTOR;
    localparam int CNT_W = beat_cnt_width(PACK_FACTOR);
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(PACK_FACTOR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [ROW_W-1:0] row_q, row_d;

    // The held row is zeroed after every completed row, so unfilled slices stay zero.
    always_comb begin
        row_data_o = row_q;
        for (int s = 0; s < PACK_FACTOR; s++) begin
            if (beat_cnt_q == CNT_W'(s)) begin
                row_data_o[s*AXIS_BUS_BIT_WIDTH +: AXIS_BUS_BIT_WIDTH] = beat_data_i;
            end
        end
        row_done_o = beat_valid_i && ((beat_cnt_q == LAST_SLICE) || beat_last_i);

        row_d      = row_q;
        beat_cnt_d = beat_cnt_q;
        if (clear_i || row_done_o) begin
            row_d      = '0;
            beat_cnt_d = '0;
        end else if (beat_valid_i) begin
            row_d      = row_data_o;
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            row_q      <= row_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: rtl/axis_weight_memory_writer.sv
// Loads a block of weights from an AXI-Stream into consecutive rows of a weight memory.
// Rows are written one cycle after they complete; errors flag early or missing s_last.
module axis_weight_memory_writer
    import axis_weight_memory_writer_pkg::*;
#(
    parameter int AXIS_BUS_BIT_WIDTH = DEFAULT_AXIS_BUS_BIT_WIDTH,
    parameter int PACK_FACTOR        = DEFAULT_PACK_FACTOR,
    parameter int MEM_ADDR_WIDTH     = DEFAULT_MEM_ADDR_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start_i,
    input  logic [MEM_ADDR_WIDTH-1:0]                 base_addr_i,
    input  logic [MEM_ADDR_WIDTH:0]                   num_rows_i,
    input  logic [AXIS_BUS_BIT_WIDTH-1:0]             s_data,
    input  logic                                      s_valid,
    input  logic                                      s_last,
    output logic                                      s_ready,
    output logic                                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]                 mem_addr_o,
    output logic [AXIS_BUS_BIT_WIDTH*PACK_FACTOR-1:0] mem_wdata_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [MEM_ADDR_WIDTH:0]                   rows_written_o,
    output logic                                      err_early_last_o,
    output logic                                      err_no_last_o
);

    localparam int ROW_W = AXIS_BUS_BIT_WIDTH * PACK_FACTOR;
    localparam logic [MEM_ADDR_WIDTH:0] ONE_ROW = (MEM_ADDR_WIDTH + 1)'(1);

    writer_state_e             state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0] base_q, base_d;
    logic [MEM_ADDR_WIDTH:0]   num_rows_q, num_rows_d;
    logic [MEM_ADDR_WIDTH:0]   rows_written_q, rows_written_d;
    logic                      mem_we_q, mem_we_d;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [ROW_W-1:0]          mem_wdata_q, mem_wdata_d;
    logic                      done_q, done_d;
    logic                      err_early_q, err_early_d;
    logic                      err_no_q, err_no_d;

    logic             beat_accept;
    logic             packer_clear;
    logic             row_done;
    logic [ROW_W-1:0] row_data;

    assign beat_accept = s_valid && (state_q == ST_RECEIVE);

    weight_row_packer #(
        .AXIS_BUS_BIT_WIDTH (AXIS_BUS_BIT_WIDTH),
        .PACK_FACTOR        (PACK_FACTOR)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (packer_clear),
        .beat_valid_i (beat_accept),
        .beat_data_i  (s_data),
        .beat_last_i  (s_last),
        .row_done_o   (row_done),
        .row_data_o   (row_data)
    );

    // The row index of a completing row is the count of rows already written.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        num_rows_d     = num_rows_q;
        rows_written_d = rows_written_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        done_d         = 1'b0;
        err_early_d    = err_early_q;
        err_no_d       = err_no_q;
        packer_clear   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i && (num_rows_i != '0)) begin
                    state_d        = ST_RECEIVE;
                    base_d         = base_addr_i;
                    num_rows_d     = num_rows_i;
                    rows_written_d = '0;
                    err_early_d    = 1'b0;
                    err_no_d       = 1'b0;
                    packer_clear   = 1'b1;
                end
            end
            ST_RECEIVE: begin
                if (row_done) begin
                    mem_we_d       = 1'b1;
                    mem_addr_d     = base_q + rows_written_q[MEM_ADDR_WIDTH-1:0];
                    mem_wdata_d    = row_data;
                    rows_written_d = rows_written_q + ONE_ROW;
                    if (rows_written_q == (num_rows_q - ONE_ROW)) begin
                        state_d  = ST_DONE;
                        done_d   = 1'b1;
                        err_no_d = !s_last;
                    end else if (s_last) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        err_early_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            num_rows_q     <= '0;
            rows_written_q <= '0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            done_q         <= 1'b0;
            err_early_q    <= 1'b0;
            err_no_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            num_rows_q     <= num_rows_d;
            rows_written_q <= rows_written_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            done_q         <= done_d;
            err_early_q    <= err_early_d;
            err_no_q       <= err_no_d;
        end
    end

    // Reset also masks a write already registered from the previous cycle.
    assign mem_we_o         = mem_we_q && !rst;
    assign done_o           = done_q && !rst;
    assign s_ready          = (state_q == ST_RECEIVE);
    assign busy_o           = (state_q != ST_IDLE);
    assign mem_addr_o       = mem_addr_q;
    assign mem_wdata_o      = mem_wdata_q;
    assign rows_written_o   = rows_written_q;
    assign err_early_last_o = err_early_q;
    assign err_no_last_o    = err_no_q;

endmodule

// File: doc/axis_weight_memory_writer.md
AXIS_WEIGHT_MEMORY_WRITER -- requirements
Module: axis_weight_memory_writer

Interface
REQ-001 SHALL have parameter AXIS_BUS_BIT_WIDTH, default 64, meaning the stream beat width.
REQ-002 SHALL have parameter PACK_FACTOR, default 2, meaning beats packed per memory row (>=1).
REQ-003 SHALL have parameter MEM_ADDR_WIDTH, default 10, meaning the weight memory address width (depth 2**MEM_ADDR_WIDTH).
REQ-004 SHALL use one clock and a synchronous, active-high reset; no other clock or reset exists.
REQ-005 clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start_i  input  1  one-cycle request to begin a load.
REQ-008 base_addr_i  input  MEM_ADDR_WIDTH  first row address, sampled on an accepted start.
REQ-009 num_rows_i  input  MEM_ADDR_WIDTH+1  expected row count, sampled on an accepted start.
REQ-010 s_data  input  AXIS_BUS_BIT_WIDTH  stream beat payload.
REQ-011 s_valid  input  1  beat valid.
REQ-012 s_last  input  1  final beat of the weight block.
REQ-013 s_ready  output  1  beat accepted when s_valid and s_ready are both high.
REQ-014 mem_we_o  output  1  row write strobe.
REQ-015 mem_addr_o  output  MEM_ADDR_WIDTH  row write address.
REQ-016 mem_wdata_o  output  AXIS_BUS_BIT_WIDTH*PACK_FACTOR  packed row data.
REQ-017 busy_o  output  1  high outside IDLE.
REQ-018 done_o  output  1  one-cycle completion pulse.
REQ-019 rows_written_o  output  MEM_ADDR_WIDTH+1  rows written in the current or most recent load.
REQ-020 err_early_last_o, err_no_last_o  output  1 each  sticky error flags, cleared on the next accepted start.

Function
REQ-021 SHALL implement states IDLE, RECEIVE, DONE.
REQ-022 IDLE: start_i with num_rows_i!=0 -> RECEIVE, latch base/count, clear row, beat and error state; start_i with num_rows_i==0 is ignored.
REQ-023 start_i outside IDLE SHALL be ignored.
REQ-024 s_ready SHALL equal (state==RECEIVE), driven from registered state only, with no combinational path from s_valid.
REQ-025 Each accepted beat SHALL be placed into row slice beat_cnt, with beat 0 in the LSBs; beat_cnt increments 0..PACK_FACTOR-1.
REQ-026 A row completes on the accepted beat where beat_cnt==PACK_FACTOR-1 or s_last==1; unfilled slices SHALL be zero.
REQ-027 A row completing at cycle t SHALL produce mem_we_o=1 for exactly one cycle at t+1, with mem_addr_o=base+rows_written (mod 2**MEM_ADDR_WIDTH) and the packed data.
REQ-028 rows_written_o SHALL increment in the same cycle as mem_we_o.
REQ-029 Completing row num_rows-1 with s_last=1: normal finish -> DONE at t+1.
REQ-030 s_last on a row before row num_rows-1: set err_early_last_o, write that partial row, -> DONE.
REQ-031 Completing row num_rows-1 with s_last=0: set err_no_last_o, -> DONE; s_ready is low from t+1, so further beats are not accepted.
REQ-032 DONE SHALL last one cycle with done_o=1, coinciding with the final mem_we_o, then -> IDLE.
REQ-033 Address wrap past 2**MEM_ADDR_WIDTH-1 to 0 SHALL be silent modular arithmetic.
REQ-034 s_valid low SHALL stall with no state change; there is no timeout.

Reset
REQ-035 rst SHALL force IDLE, and set s_ready, mem_we_o, done_o, busy_o and both error flags to 0.
REQ-036 rst SHALL set mem_addr_o, mem_wdata_o, rows_written_o and internal counters to 0.
REQ-037 rst mid-load SHALL abort the load with no further write, including a write pending from the previous cycle.

Structure
REQ-038 A shared package SHALL hold the state enum type and the default width constants.
REQ-039 Beat-to-row packing (slice register, beat counter, zero fill) SHALL be the sub-module weight_row_packer; the FSM, address and count logic stay in the top.

Verification
REQ-040 Scenario 1: base=0x010, rows=3, 6 beats 0x1..0x6, last on beat 6 -> writes {0x2,0x1}@0x010, {0x4,0x3}@0x011, {0x6,0x5}@0x012; done_o at the third write; no errors.
REQ-041 Scenario 2: rows=4, last on beat 3 -> rows {0x2,0x1}@base and {0x0,0x3}@base+1 written; err_early_last_o=1; rows_written_o=2.
REQ-042 Scenario 3: rows=1, 3 beats with no last -> one write; err_no_last_o=1; beat 3 not accepted (s_ready=0).
REQ-043 Scenario 4: base=0x3FF, rows=2 -> writes at 0x3FF then 0x000.
REQ-044 Scenario 5: random s_valid gaps, plus start pulses during RECEIVE -> data identical to the gap-free run and the extra starts ignored.
REQ-045 Scenario 6: rst asserted the cycle after a row completes -> no mem_we_o; all outputs zero; next start runs a clean load.
